// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_pkg
// Purpose  : Shared constants and the per-channel debounce state encoding
//            used by button_conditioner and debounce_channel.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

    localparam int CLK30_FREQ = 30000000;

    // Bit 1 of the encoding marks the "pressed" half of the state space.
    typedef enum logic [1:0] {
        REL_STABLE = 2'b00,
        REL_WAIT   = 2'b01,
        PRS_STABLE = 2'b10,
        PRS_WAIT   = 2'b11
    } chan_state_t;

endpackage : button_conditioner_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One button channel: two-flop synchroniser on an active-low pin,
//            a 4-state debounce FSM with stable-time counter, and registered
//            level / press-strobe / release-strobe outputs.
// Ports    : clk30         - system clock
//            rst_n         - asynchronous active-low reset
//            button        - raw active-low pin, asynchronous to clk30
//            pressed       - debounced level, 1 = held
//            press_pulse   - one-cycle strobe on an accepted press
//            release_pulse - one-cycle strobe on an accepted release
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk30,
    input  logic rst_n,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic        sync_meta;
    logic        sync_n;
    logic        act;
    chan_state_t state;
    chan_state_t state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic        press_nx;
    logic        release_nx;

    // Synchroniser resets to the released pin level so a button already
    // held at reset exit is treated as a fresh press.
    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_n    <= 1'b1;
        end else begin
            sync_meta <= button;
            sync_n    <= sync_meta;
        end
    end

    assign act = ~sync_n;

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= REL_STABLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pressed       <= (state_nx == PRS_STABLE) || (state_nx == PRS_WAIT);
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
        end
    end

    // In the wait states the opposite level is tested before the terminal
    // count, so a bounce on the last cycle is still rejected.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
            REL_STABLE: begin
                cnt_nx = '0;
                if (act) begin
                    state_nx = REL_WAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            REL_WAIT: begin
                if (!act) begin
                    state_nx = REL_STABLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_nx = PRS_STABLE;
                    cnt_nx   = '0;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            PRS_STABLE: begin
                cnt_nx = '0;
                if (!act) begin
                    state_nx = PRS_WAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            PRS_WAIT: begin
                if (act) begin
                    state_nx = PRS_STABLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_nx   = REL_STABLE;
                    cnt_nx     = '0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = REL_STABLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises and debounces NUM_BUTTONS raw active-low push
//            buttons independently, giving a clean active-high level and
//            one-cycle press / release strobes per button.
// Ports    : clk30         - system clock, the only clock
//            rst_n         - asynchronous active-low reset
//            button        - raw active-low pins [NUM_BUTTONS]
//            pressed       - debounced levels, 1 = held [NUM_BUTTONS]
//            press_pulse   - press strobes [NUM_BUTTONS]
//            release_pulse - release strobes [NUM_BUTTONS]
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLK_FREQ    = CLK30_FREQ,
    parameter int DEBOUNCE_MS = 10,
    parameter int NUM_BUTTONS = 2
) (
    input  logic                   clk30,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] button,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse
);

    // Must be at least 2 so the wait states have a distinct terminal count.
    localparam int DEBOUNCE_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1);

    genvar i;
    generate
        for (i = 0; i < NUM_BUTTONS; i++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .clk30         (clk30),
                .rst_n         (rst_n),
                .button        (button[i]),
                .pressed       (pressed[i]),
                .press_pulse   (press_pulse[i]),
                .release_pulse (release_pulse[i])
            );
        end
    endgenerate

endmodule : button_conditioner
`default_nettype wire
